// File: rtl/bcd_score_to_binary_pkg.sv
// Shared types and constants for the BCD-to-binary score limit decoder.
package bcd_score_to_binary_pkg;

   typedef enum logic {
      IDLE    = 1'b0,
      CONVERT = 1'b1
   } conv_state_e;

   localparam int DIGITS_DEF = 3;
   localparam int BIN_W_DEF  = 10;
   localparam int BCD_W      = 4 * DIGITS_DEF;
   localparam int CNT_W      = $clog2(BIN_W_DEF + 1);

   localparam logic [3:0] DIGIT_MAX    = 4'd9;
   localparam logic [3:0] CORR_THRESH  = 4'd8;
   localparam logic [3:0] CORR_CONST   = 4'd3;

endpackage

// File: rtl/bcd_digit_sub_three.sv
// One BCD digit correction step of reverse double-dabble: 8 or more loses 3.
module bcd_digit_sub_three
   import bcd_score_to_binary_pkg::*;
(
   input  logic [3:0] digit_i,
   output logic [3:0] digit_o
);

   // Conditional 4-bit unsigned subtract after the right shift.
   always_comb begin
      digit_o = digit_i;
      if (digit_i >= CORR_THRESH) begin
         digit_o = digit_i - CORR_CONST;
      end else begin
         digit_o = digit_i;
      end
   end

endmodule

// File: rtl/bcd_score_to_binary.sv
// Sequential packed-BCD to binary converter, one shift/correct iteration per clock,
// with start/busy/done handshake and invalid-digit error reporting.
module bcd_score_to_binary
   import bcd_score_to_binary_pkg::*;
#(
   parameter int DIGITS = DIGITS_DEF,
   parameter int BIN_W  = BIN_W_DEF
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [4*DIGITS-1:0]   bcd_in,
   output logic [BIN_W-1:0]      binary_out,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

   localparam int LBCD_W = 4 * DIGITS;
   localparam int LCNT_W = $clog2(BIN_W + 1);
   localparam int SR_W   = LBCD_W + BIN_W;
   localparam logic [LCNT_W-1:0] LAST_ITER = LCNT_W'(BIN_W - 1);

   conv_state_e         state_q;
   logic [SR_W-1:0]     sr_q;
   logic [SR_W-1:0]     sr_d;
   logic [SR_W-1:0]     shifted_s;
   logic [LBCD_W-1:0]   corr_s;
   logic [LCNT_W-1:0]   cnt_q;
   logic [BIN_W-1:0]    binary_q;
   logic                busy_q;
   logic                done_q;
   logic                err_q;
   logic [DIGITS-1:0]   bad_digit_s;
   logic                any_bad_s;

   genvar g;
   generate
      for (g = 0; g < DIGITS; g++) begin : g_digit
         bcd_digit_sub_three u_sub3 (
            .digit_i (shifted_s[BIN_W + 4*g +: 4]),
            .digit_o (corr_s[4*g +: 4])
         );
         assign bad_digit_s[g] = (bcd_in[4*g +: 4] > DIGIT_MAX);
      end
   endgenerate

   assign any_bad_s = |bad_digit_s;

   // One iteration: shift whole register right, then correct each BCD digit.
   always_comb begin
      shifted_s = {1'b0, sr_q[SR_W-1:1]};
      sr_d      = {corr_s, shifted_s[BIN_W-1:0]};
   end

   // Control FSM with all outputs registered; done is forced low every edge unless set.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q  <= IDLE;
         sr_q     <= '0;
         cnt_q    <= '0;
         binary_q <= '0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start) begin
                  if (any_bad_s) begin
                     done_q   <= 1'b1;
                     err_q    <= 1'b1;
                     binary_q <= '0;
                  end else begin
                     sr_q    <= {bcd_in, {BIN_W{1'b0}}};
                     cnt_q   <= '0;
                     busy_q  <= 1'b1;
                     err_q   <= 1'b0;
                     state_q <= CONVERT;
                  end
               end
            end
            CONVERT: begin
               sr_q  <= sr_d;
               cnt_q <= cnt_q + LCNT_W'(1);
               if (cnt_q == LAST_ITER) begin
                  binary_q <= shifted_s[BIN_W-1:0];
                  done_q   <= 1'b1;
                  busy_q   <= 1'b0;
                  state_q  <= IDLE;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign binary_out = binary_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;

endmodule

// File: tb/tb_bcd_score_to_binary.sv
// Directed self-checking bench for bcd_score_to_binary.
module tb_bcd_score_to_binary;

   logic        clk;
   logic        rst;
   logic        start;
   logic [11:0] bcd_in;
   logic [9:0]  binary_out;
   logic        busy;
   logic        done;
   logic        err;

   int checks   = 0;
   int failures = 0;

   bcd_score_to_binary dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .bcd_in     (bcd_in),
      .binary_out (binary_out),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Accept at E0 on a one-cycle start, busy through E9, done after E10.
   task automatic do_conv(input logic [11:0] v, input logic [9:0] exp_bin, input string tag);
      @(negedge clk);
      bcd_in = v;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      bcd_in = 12'hFFF;
      chk({tag, "_busy_e0"}, 32'(busy), 32'd1);
      chk({tag, "_done_e0"}, 32'(done), 32'd0);
      for (int k = 1; k <= 9; k++) begin
         @(negedge clk);
         chk({tag, "_busy_run"}, 32'(busy), 32'd1);
         chk({tag, "_done_run"}, 32'(done), 32'd0);
      end
      @(negedge clk);
      chk({tag, "_done"}, 32'(done), 32'd1);
      chk({tag, "_busy_end"}, 32'(busy), 32'd0);
      chk({tag, "_bin"}, 32'(binary_out), 32'(exp_bin));
      chk({tag, "_err"}, 32'(err), 32'd0);
      chk({tag, "_bcd_zero"}, 32'(dut.sr_q[10 +: 12]), 32'd0);
      @(negedge clk);
      chk({tag, "_done_clr"}, 32'(done), 32'd0);
      chk({tag, "_bin_hold"}, 32'(binary_out), 32'(exp_bin));
   endtask

   initial begin
      rst    = 1'b0;
      start  = 1'b0;
      bcd_in = 12'h000;
      repeat (3) @(negedge clk);
      chk("rst_bin", 32'(binary_out), 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         chk("idle_done", 32'(done), 32'd0);
      end

      do_conv(12'h255, 10'd255, "c255");
      do_conv(12'h000, 10'd0, "c000");
      do_conv(12'h999, 10'h3E7, "c999");

      // Invalid digit: immediate done+err, no busy.
      @(negedge clk);
      bcd_in = 12'h1A3;
      start  = 1'b1;
      @(negedge clk);
      start  = 1'b0;
      chk("inv_done", 32'(done), 32'd1);
      chk("inv_err", 32'(err), 32'd1);
      chk("inv_busy", 32'(busy), 32'd0);
      chk("inv_bin", 32'(binary_out), 32'd0);
      @(negedge clk);
      chk("inv_done_clr", 32'(done), 32'd0);
      chk("inv_err_hold", 32'(err), 32'd1);
      chk("inv_busy2", 32'(busy), 32'd0);
      do_conv(12'h007, 10'd7, "c007");

      // Start held high: back-to-back, bcd_in change during CONVERT ignored.
      @(negedge clk);
      bcd_in = 12'h100;
      start  = 1'b1;
      @(negedge clk);
      bcd_in = 12'h042;
      chk("b2b_busy0", 32'(busy), 32'd1);
      repeat (9) @(negedge clk);
      @(negedge clk);
      chk("b2b_done1", 32'(done), 32'd1);
      chk("b2b_bin1", 32'(binary_out), 32'd100);
      @(negedge clk);
      start = 1'b0;
      chk("b2b_busy2", 32'(busy), 32'd1);
      chk("b2b_done_clr", 32'(done), 32'd0);
      for (int k = 0; k < 9; k++) begin
         @(negedge clk);
         chk("b2b_run2", 32'(busy), 32'd1);
      end
      @(negedge clk);
      chk("b2b_done2", 32'(done), 32'd1);
      chk("b2b_bin2", 32'(binary_out), 32'd42);

      // Start pulse while busy must be ignored.
      @(negedge clk);
      bcd_in = 12'h300;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (2) @(negedge clk);
      bcd_in = 12'h888;
      start  = 1'b1;
      @(negedge clk);
      start = 1'b0;
      chk("ign_bin_mid", 32'(binary_out), 32'd42);
      repeat (6) @(negedge clk);
      @(negedge clk);
      chk("ign_done", 32'(done), 32'd1);
      chk("ign_bin", 32'(binary_out), 32'd300);
      @(negedge clk);
      chk("ign_busy_after", 32'(busy), 32'd0);
      chk("ign_done_after", 32'(done), 32'd0);

      // Asynchronous reset at E5 of a conversion.
      @(negedge clk);
      bcd_in = 12'h500;
      start  = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (5) @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("arst_busy", 32'(busy), 32'd0);
      chk("arst_bin", 32'(binary_out), 32'd0);
      chk("arst_done", 32'(done), 32'd0);
      chk("arst_err", 32'(err), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         chk("arst_no_done", 32'(done), 32'd0);
      end
      do_conv(12'h021, 10'd21, "c021");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/bcd_score_to_binary.md
Name: bcd_score_to_binary

Overview:
- Sequential BCD-to-binary decoder built on the reverse double-dabble method: shift right, then subtract 3 from any digit that is 8 or more.
- Converts a 3-digit packed BCD value (for example, a win-score limit or preset entered as decimal digits on switches) into a 10-bit binary value that the score logic can compare against the score counter.
- It is the inverse of the score display's binary-to-BCD path, and sits between the digit-entry logic and the game-control FSM.
- It uses a start/busy/done handshake, one iteration per clock.

Parameters:
- DIGITS, 3: number of packed BCD digits on bcd_in.
- BIN_W, 10: binary result width and iteration count. Must satisfy 2^BIN_W > 10^DIGITS - 1.

Ports:
- clk, input, 1: system clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- start, input, 1: request a conversion. Sampled only in IDLE.
- bcd_in, input, 4*DIGITS: packed BCD; digit 0 is in bits [3:0].
- binary_out, output, BIN_W: conversion result. Holds its value between conversions.
- busy, output, 1: high while a conversion is in progress.
- done, output, 1: one-cycle pulse when the result or error is valid.
- err, output, 1: an invalid digit was seen in the last accepted request.

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, binary_out=0, busy=0, done=0, err=0, and all internal registers cleared. Reset mid-conversion aborts the conversion; no done is produced afterwards.
- States are IDLE, CONVERT.
- IDLE with start=1 (accept edge, E0):
  - If every digit of bcd_in is 9 or less: load shift register {bcd_in, BIN_W'b0}, iteration count=0, busy<=1, err<=0, go to CONVERT.
  - If any digit is 10 or more: stay in IDLE, done<=1 and err<=1 at E0, binary_out<=0, busy stays 0.
- CONVERT, each edge:
  - Shift the whole {bcd, bin} register right by 1.
  - Then, in each shifted BCD digit, if the digit is 8 or more, subtract 3 (the correction is combinational, same edge).
  - Increment the iteration count.
- Termination:
  - On the edge performing iteration BIN_W (count = BIN_W-1), load binary_out with the post-shift binary field, set done<=1, busy<=0, return to IDLE.
  - With defaults, done rises on edge E10 (the 10th rising edge after E0), and busy is high from E0 until E10.
- done is a single-cycle pulse; it is cleared on the next edge.
- err holds until the next accepted start.
- start while busy is ignored; no queueing.
- start held high continuously causes back-to-back conversions. The cycle in which done=1 is IDLE, so start is accepted there.
- bcd_in is only captured at accept. Changes to bcd_in during CONVERT have no effect.
- binary_out changes only on done (a successful conversion, or 0 on error). It is never a partial value.
- Arithmetic: the digit correction is a 4-bit unsigned subtract. The result of the final iteration's correction is discarded. The BCD field must be all zero at completion; the bench asserts this internally as a check, and it is not an output.

Decomposition:
- Shared package holds:
  - state enum {IDLE, CONVERT};
  - localparam BCD_W = 4*DIGITS;
  - iteration counter width = clog2(BIN_W+1);
  - digit-validity limit 4'd9;
  - correction threshold 4'd8 and correction constant 4'd3.
- One sub-module, bcd_digit_sub_three: 4-bit in/out, combinational "digit 8 or more, subtract 3". It is instantiated DIGITS times via a generate loop.

Test Plan:
- Reset then idle: rst low for 3 cycles, then high. Check binary_out=0, busy=0, done=0, err=0, and that no done appears over 20 cycles with start=0.
- bcd_in=12'h255, 1-cycle start:
  - busy high from E0 through E9;
  - done=1 only in the cycle after E10;
  - binary_out=10'd255, err=0.
- Boundary values:
  - bcd_in=12'h999 gives binary_out=10'd999 (10'h3E7);
  - bcd_in=12'h000 gives 0, with done still pulsing at E10.
- Invalid digit: bcd_in=12'h1A3 with start gives done=1 and err=1 at E0, busy never high, binary_out=0. A following valid 12'h007 gives 7 and clears err.
- Handshake:
  - start held high with 12'h100, switched to 12'h042 during CONVERT: the first result is 100, the second is accepted on the done cycle and gives 42.
  - start pulses during busy are ignored.
- Reset mid-operation: assert rst at E5 of a 12'h500 conversion. Outputs go to 0 immediately (asynchronously). After release, a new 12'h021 start gives 21.
